// File: rtl/comparador_sequencial_param_if.sv
// Operand/result bundle for comparador_sequencial_param: operand offer with
// handshake on one side, registered result with handshake on the other.
interface comparador_sequencial_param_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic [WIDTH-1:0] mask;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic             fi;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CNT_W-1:0] match_cnt;
  logic             run_hit;

  modport master (
    output in_valid, a, b, mode, mask, clear, out_ready,
    input  in_ready, out_valid, fi, eq, gt, lt, match_cnt, run_hit
  );

  modport slave (
    input  in_valid, a, b, mode, mask, clear, out_ready,
    output in_ready, out_valid, fi, eq, gt, lt, match_cnt, run_hit
  );
endinterface

// File: rtl/comparador_sequencial_param.sv
// Registered WIDTH-bit comparator with selectable mode, one-deep valid/ready
// result register, saturating match counter and consecutive-match run detector.
module comparador_sequencial_param #(
  parameter int WIDTH   = 3,
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input logic clk,
  input logic rst,
  comparador_sequencial_param_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic fi;
    logic eq;
    logic gt;
    logic lt;
    logic run_hit;
  } res_t;

  localparam logic [7:0]       RUN_MAX = 8'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  res_t             res_q, res_nxt;
  logic [7:0]       run_cnt, run_base, run_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_nxt;
  logic             in_ready, out_valid, acc, drn;
  logic             eq_c, gt_c, lt_c, fi_c;

  assign in_ready = !out_valid | bus.out_ready;
  assign acc      = bus.in_valid & in_ready;
  assign drn      = out_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    case (state)
      EMPTY: if (acc) state_nxt = FULL;
      FULL: begin
        out_valid = 1'b1;
        if (drn && !acc) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    eq_c = (bus.a == bus.b);
    gt_c = (bus.a >  bus.b);
    lt_c = (bus.a <  bus.b);
    case (bus.mode)
      2'b00:   fi_c = eq_c;
      2'b01:   fi_c = gt_c;
      2'b10:   fi_c = lt_c;
      default: fi_c = ((bus.a & bus.mask) == (bus.b & bus.mask));
    endcase

    // CLEAR takes effect before the same-cycle transaction is counted
    run_base = bus.clear ? 8'd0 : run_cnt;
    cnt_base = bus.clear ? '0   : cnt_q;

    run_nxt = run_base;
    if (acc) run_nxt = fi_c ? ((run_base >= RUN_MAX) ? RUN_MAX : run_base + 8'd1) : 8'd0;

    cnt_nxt = cnt_base;
    if (acc && fi_c && cnt_base != CNT_MAX) cnt_nxt = cnt_base + CNT_W'(1);

    res_nxt = '{fi: fi_c, eq: eq_c, gt: gt_c, lt: lt_c, run_hit: (run_nxt == RUN_MAX)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      res_q   <= '0;
      run_cnt <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      cnt_q   <= cnt_nxt;
      if (acc) res_q <= res_nxt;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.fi        = res_q.fi;
  assign bus.eq        = res_q.eq;
  assign bus.gt        = res_q.gt;
  assign bus.lt        = res_q.lt;
  assign bus.run_hit   = res_q.run_hit;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_comparador_sequencial_param.sv
// Scoreboard bench: two instances (CNT_W=8 and CNT_W=2) share one stimulus
// stream; a queue-based model predicts results, a negedge monitor compares.
module tb_comparador_sequencial_param;
  localparam int W  = 3;
  localparam int RL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comparador_sequencial_param_if #(.WIDTH(W), .CNT_W(8)) i8 ();
  comparador_sequencial_param_if #(.WIDTH(W), .CNT_W(2)) i2 ();

  comparador_sequencial_param #(.WIDTH(W), .CNT_W(8), .RUN_LEN(RL)) u_dut8 (.clk(clk), .rst(rst), .bus(i8));
  comparador_sequencial_param #(.WIDTH(W), .CNT_W(2), .RUN_LEN(RL)) u_dut2 (.clk(clk), .rst(rst), .bus(i2));

  assign i2.in_valid  = i8.in_valid;
  assign i2.a         = i8.a;
  assign i2.b         = i8.b;
  assign i2.mode      = i8.mode;
  assign i2.mask      = i8.mask;
  assign i2.clear     = i8.clear;
  assign i2.out_ready = i8.out_ready;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic fi;
    logic eq;
    logic gt;
    logic lt;
    logic rh;
  } exp_t;

  exp_t q[$];
  int   hits = 0;   // FI=1 results since last clear/reset, unbounded
  int   run  = 0;   // current consecutive FI=1 streak, unbounded
  bit   m_acc, m_drn;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      hits = 0;
      run  = 0;
    end else begin
      exp_t e;
      m_acc = i8.in_valid && (q.size() == 0 || i8.out_ready);
      m_drn = (q.size() != 0) && i8.out_ready;
      if (i8.clear) begin hits = 0; run = 0; end
      if (m_drn) void'(q.pop_front());
      if (m_acc) begin
        e.eq = (i8.a == i8.b);
        e.gt = (i8.a >  i8.b);
        e.lt = (i8.a <  i8.b);
        case (i8.mode)
          2'd0:    e.fi = e.eq;
          2'd1:    e.fi = e.gt;
          2'd2:    e.fi = e.lt;
          default: e.fi = ((i8.a & i8.mask) == (i8.b & i8.mask));
        endcase
        if (e.fi) begin hits++; run++; end
        else run = 0;
        e.rh = (run >= RL);
        q.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("in_ready8", 32'(i8.in_ready), 32'((q.size() == 0) || i8.out_ready));
    chk("in_ready2", 32'(i2.in_ready), 32'((q.size() == 0) || i8.out_ready));
    chk("match_cnt8", 32'(i8.match_cnt), 32'(sat(hits, 255)));
    chk("match_cnt2", 32'(i2.match_cnt), 32'(sat(hits, 3)));
    chk("out_valid8", 32'(i8.out_valid), 32'(q.size() != 0));
    chk("out_valid2", 32'(i2.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("res8", 32'({i8.fi, i8.eq, i8.gt, i8.lt, i8.run_hit}),
          32'({q[0].fi, q[0].eq, q[0].gt, q[0].lt, q[0].rh}));
      chk("res2", 32'({i2.fi, i2.eq, i2.gt, i2.lt, i2.run_hit}),
          32'({q[0].fi, q[0].eq, q[0].gt, q[0].lt, q[0].rh}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [W-1:0] a_, input logic [W-1:0] b_,
                      input logic [1:0] m_, input logic [W-1:0] k_, input logic c_);
    i8.in_valid = 1'b1;
    i8.a = a_; i8.b = b_; i8.mode = m_; i8.mask = k_; i8.clear = c_;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    i8.clear    = 1'b0;
  endtask

  task automatic idle_clear();
    i8.clear = 1'b1;
    @(posedge clk); #1;
    i8.clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] rh_exp;
    i8.in_valid = 0; i8.a = 0; i8.b = 0; i8.mode = 0; i8.mask = 0;
    i8.clear = 0; i8.out_ready = 1;
    #2;
    chk("rst_in_ready", 32'(i8.in_ready), 32'd1);
    chk("rst_out_valid", 32'(i8.out_valid), 32'd0);
    chk("rst_outs", 32'({i8.fi, i8.eq, i8.gt, i8.lt, i8.run_hit}), 32'd0);
    chk("rst_cnt", 32'(i8.match_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // equality sweep, back-to-back
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        send(W'(x), W'(y), 2'b00, '0, 1'b0);
        chk("sweep_fi", 32'(i8.fi), 32'(x == y));
      end
    chk("sweep_cnt8", 32'(i8.match_cnt), 32'd8);
    chk("sweep_cnt2", 32'(i2.match_cnt), 32'd3);

    // magnitude and masked modes
    send(3'd5, 3'd3, 2'b01, '0, 1'b0);
    chk("gt_fi", 32'({i8.fi, i8.gt}), 32'b11);
    send(3'd5, 3'd3, 2'b10, '0, 1'b0);
    chk("lt_neg", 32'({i8.fi, i8.lt, i8.gt}), 32'b001);
    send(3'd2, 3'd7, 2'b10, '0, 1'b0);
    chk("lt_pos", 32'({i8.fi, i8.lt}), 32'b11);
    send(3'b101, 3'b001, 2'b11, 3'b011, 1'b0);
    chk("mask_hit", 32'({i8.fi, i8.eq, i8.gt}), 32'b101);
    send(3'b101, 3'b001, 2'b11, 3'b111, 1'b0);
    chk("mask_full", 32'(i8.fi), 32'd0);
    send(3'd5, 3'd2, 2'b11, 3'b000, 1'b0);
    chk("mask_zero", 32'(i8.fi), 32'd1);

    // back-pressure
    idle_clear();
    i8.out_ready = 1'b0;
    send(3'd6, 3'd6, 2'b00, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(i8.in_ready), 32'd0);
      chk("bp_hold", 32'({i8.out_valid, i8.fi, i8.eq, i8.match_cnt}), 32'({3'b111, 8'd1}));
      i8.in_valid = 1'b1; i8.a = W'($urandom); i8.b = W'($urandom); i8.mode = 2'($urandom);
      @(posedge clk); #1;
    end
    i8.a = 3'd1; i8.b = 3'd2; i8.mode = 2'b00; i8.in_valid = 1'b1;
    i8.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(i8.in_ready), 32'd1);
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    chk("bp_new", 32'({i8.out_valid, i8.fi, i8.lt, i8.match_cnt}), 32'({3'b101, 8'd1}));

    // run detection and saturation
    idle_clear();
    rh_exp = 3'd0;
    for (int i = 1; i <= 7; i++) begin
      if (i < 7) send(3'd4, 3'd4, 2'b00, '0, 1'b0);
      else       send(3'd4, 3'd1, 2'b00, '0, 1'b0);
      rh_exp[0] = (i >= 4 && i <= 6);
      chk("run_hit", 32'(i2.run_hit), 32'(rh_exp[0]));
      chk("sat_cnt2", 32'(i2.match_cnt), 32'(sat(i, 3)));
    end

    // CLEAR together with an accepted equal pair
    send(3'd3, 3'd3, 2'b00, '0, 1'b1);
    chk("clr_acc_cnt8", 32'(i8.match_cnt), 32'd1);
    chk("clr_acc_rh", 32'(i8.run_hit), 32'd0);

    // reset while a result is pending
    i8.out_ready = 1'b0;
    send(3'd4, 3'd4, 2'b00, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(i8.out_valid), 32'd0);
    chk("mid_rst_ir", 32'(i8.in_ready), 32'd1);
    chk("mid_rst_cnt", 32'(i8.match_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    i8.out_ready = 1'b1;
    @(posedge clk); #1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      i8.in_valid  = ($urandom % 4) != 0;
      i8.out_ready = ($urandom % 3) != 0;
      i8.a         = W'($urandom);
      i8.b         = ($urandom % 2 == 0) ? i8.a : W'($urandom);
      i8.mode      = 2'($urandom);
      i8.mask      = ($urandom % 4 == 0) ? '0 : W'($urandom);
      i8.clear     = ($urandom % 16) == 0;
      @(posedge clk); #1;
    end
    i8.in_valid = 1'b0; i8.clear = 1'b0; i8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/comparador_sequencial_param.md
# comparador_sequencial_param

Parametrised, registered successor to the team's 3-bit combinational equality comparator. Compares two WIDTH-bit operands under a selectable mode (equal, greater, less, masked-equal) and presents the result through a one-deep valid/ready output register. It also keeps a saturating match counter and a consecutive-match run detector. It sits between an operand source and a consumer that may stall.

## Interface
- WIDTH, 3, operand width in bits (≥1)
- CNT_W, 8, width of MATCH_CNT (≥1)
- RUN_LEN, 4, consecutive FI=1 results needed to raise RUN_HIT (1 ≤ RUN_LEN ≤ 255)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- IN_VALID  in  1  operand transaction offered
- IN_READY  out  1  block can accept this cycle
- A  in  WIDTH  operand A (unsigned)
- B  in  WIDTH  operand B (unsigned)
- MODE  in  2  00 A==B, 01 A>B, 10 A<B, 11 (A&MASK)==(B&MASK)
- MASK  in  WIDTH  bit mask, used only in MODE 11
- CLEAR  in  1  synchronous clear of MATCH_CNT and run counter
- OUT_VALID  out  1  result register holds an unconsumed result
- OUT_READY  in  1  consumer takes result this cycle
- FI  out  1  mode-selected comparison result
- EQ, GT, LT  out  1 each  raw unmasked relations of the captured operands (exactly one high while OUT_VALID)
- MATCH_CNT  out  CNT_W  number of accepted transactions with FI=1, saturating
- RUN_HIT  out  1  this result completes or extends a run of ≥RUN_LEN consecutive FI=1

## Operation
- Accept: acc = IN_VALID & IN_READY. Drain: drn = OUT_VALID & OUT_READY.
- IN_READY = !OUT_VALID | OUT_READY (combinational; full throughput when consumer never stalls).
- FSM, two states. EMPTY: OUT_VALID=0; acc → FULL. FULL: OUT_VALID=1; drn & !acc → EMPTY; drn & acc → stay FULL with new result; !drn → hold every output stable.
- On acc, capture into result register: EQ/GT/LT from unsigned A vs B; FI per MODE, sampled together with A, B and MASK in the same cycle.
- MODE 11 with MASK=0 always gives FI=1.
- Run counter run_cnt (8 bit, internal): on acc, FI=1 → min(run_cnt+1, RUN_LEN); FI=0 → 0. RUN_HIT is registered with the result and equals (next run_cnt == RUN_LEN).
- MATCH_CNT: on acc with FI=1, increments; holds at 2^CNT_W−1 and never wraps.
- CLEAR with no acc: MATCH_CNT=0 and run_cnt=0 next cycle. The result register is untouched.
- CLEAR with acc in the same cycle: clear first, then count the new transaction (MATCH_CNT = FI, run_cnt = FI). RUN_HIT = FI when RUN_LEN=1, otherwise 0.
- Counters change only on acc or CLEAR, never on drain.

## Timing
- Latency: operands accepted at edge N appear on FI/EQ/GT/LT/RUN_HIT/OUT_VALID after edge N (visible in cycle N+1). MATCH_CNT updates on the same edge.
- Throughput: 1 transaction/cycle while OUT_READY=1.
- Back-pressure: while OUT_VALID=1 & OUT_READY=0, IN_READY=0 and all outputs hold. A, B, MODE and MASK are don't-care in that window.
- Reset (async assert, released synchronously by the clock domain): OUT_VALID=0, FI=0, EQ=0, GT=0, LT=0, RUN_HIT=0, MATCH_CNT=0, run_cnt=0, FSM=EMPTY. IN_READY=1 as soon as reset is asserted.
- Reset mid-transaction: a pending result is discarded and not delivered.
- No output depends combinationally on A/B; only IN_READY depends on OUT_VALID/OUT_READY.

## Test plan
- Equality sweep, WIDTH=3, MODE=00, OUT_READY=1: all 64 (A,B) pairs back-to-back. Required: FI=1 only when A==B; exactly 8 hits; MATCH_CNT=8; one result per cycle, each 1 cycle after its input.
- Magnitude: MODE=01 with A=5,B=3 → FI=1,GT=1. MODE=10 with A=5,B=3 → FI=0,LT=0,GT=1. MODE=10 with A=2,B=7 → FI=1,LT=1.
- Masked: MODE=11, MASK=3'b011, A=3'b101, B=3'b001 → FI=1, EQ=0, GT=1. Same operands with MASK=3'b111 → FI=0.
- Back-pressure: accept A=B=6, hold OUT_READY=0 for 5 cycles. Required: IN_READY=0, outputs stable, MATCH_CNT=1 throughout. Release OUT_READY with a new offer: drain and accept occur in the same cycle.
- Run and saturation: RUN_LEN=4, CNT_W=2, six consecutive equal pairs then one unequal. Required: RUN_HIT on results 4,5,6, then 0; MATCH_CNT is 1,2,3,3,3,3 and stays 3.
- CLEAR/reset corners: CLEAR with acc of an equal pair → MATCH_CNT=1. Assert rst while OUT_VALID=1 → OUT_VALID=0 immediately, MATCH_CNT=0, IN_READY=1.
